// File: rtl/simd_commit_unit_if.sv
// ---------------------------------------------------------------------------
// simd_commit_unit_if
//   Bundles the issue-side handshake, the writeback-side handshake and the
//   status outputs of simd_commit_unit.
//
//   Issue side      : inst_rdy / inst_ack plus instruction fields
//                     (i_bofs, i_aofs, i_pc, i_warpid)
//   Writeback side  : wb_rdy / wb_ack plus the fields of the presented
//                     instruction (o_bofs, o_aofs, o_pc, o_warpid)
//   Status          : inst_commit_dval (one pulse per retired instruction),
//                     o_busy (anything buffered or in flight)
//
//   modport master : issuer + writeback consumer (drives rdy/fields, wb_ack)
//   modport slave  : the commit unit itself
// ---------------------------------------------------------------------------
interface simd_commit_unit_if #(
  parameter int WBW     = 16,
  parameter int VDIM    = 2,
  parameter int INST_BW = 4,
  parameter int WID_BW  = 2
);

  logic                           inst_rdy;
  logic                           inst_ack;
  logic [VDIM-1:0][WBW-1:0]       i_bofs;
  logic [VDIM-1:0][WBW-1:0]       i_aofs;
  logic [INST_BW-1:0]             i_pc;
  logic [WID_BW-1:0]              i_warpid;

  logic                           wb_rdy;
  logic                           wb_ack;
  logic [VDIM-1:0][WBW-1:0]       o_bofs;
  logic [VDIM-1:0][WBW-1:0]       o_aofs;
  logic [INST_BW-1:0]             o_pc;
  logic [WID_BW-1:0]              o_warpid;

  logic                           inst_commit_dval;
  logic                           o_busy;

  modport master (
    output inst_rdy, i_bofs, i_aofs, i_pc, i_warpid, wb_ack,
    input  inst_ack, wb_rdy, o_bofs, o_aofs, o_pc, o_warpid,
           inst_commit_dval, o_busy
  );

  modport slave (
    input  inst_rdy, i_bofs, i_aofs, i_pc, i_warpid, wb_ack,
    output inst_ack, wb_rdy, o_bofs, o_aofs, o_pc, o_warpid,
           inst_commit_dval, o_busy
  );

endinterface

// File: rtl/simd_commit_unit.sv
// ---------------------------------------------------------------------------
// simd_commit_unit
//   Accepts instructions from an issuer into an N_PENDING-deep FIFO, carries
//   them through a LAT-stage execution pipeline and presents them in order
//   for writeback. A registered pulse marks each retired instruction.
//
//   Ports
//     i_clk  : clock, rising edge
//     i_rst  : asynchronous, active-low reset
//     bus    : simd_commit_unit_if.slave
//              inst_rdy/inst_ack + i_* fields   (issue)
//              wb_rdy/wb_ack + o_* fields       (writeback, last stage)
//              inst_commit_dval, o_busy         (status)
//
//   Behaviour notes
//     - inst_ack = inst_rdy & !full; a full FIFO never accepts, even in a
//       cycle where it is also popped.
//     - A push never bypasses the FIFO: a new instruction reaches stage 1 no
//       earlier than two cycles after acceptance.
//     - The pipeline advances whenever the last stage is empty or is being
//       accepted by the writeback consumer; otherwise everything (stages and
//       FIFO read side) holds.
// ---------------------------------------------------------------------------
module simd_commit_unit #(
  parameter int N_PENDING = 4,
  parameter int LAT       = 3,
  parameter int WBW       = 16,
  parameter int VDIM      = 2,
  parameter int INST_BW   = 4,
  parameter int WID_BW    = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  simd_commit_unit_if.slave   bus
);

  localparam int PTR_W = (N_PENDING > 1) ? $clog2(N_PENDING) : 1;
  localparam int CNT_W = $clog2(N_PENDING + 1);

  typedef struct packed {
    logic [VDIM-1:0][WBW-1:0] bofs;
    logic [VDIM-1:0][WBW-1:0] aofs;
    logic [INST_BW-1:0]       pc;
    logic [WID_BW-1:0]        warpid;
  } inst_t;

  // FIFO state
  inst_t              r_mem [N_PENDING];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;

  // Pipeline state; index LAT-1 is the stage presented for writeback
  logic [LAT-1:0]     r_vld;
  inst_t              r_stg [LAT];

  logic               r_commit;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_adv;
  inst_t              w_in;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_PENDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full  = (r_count == CNT_W'(N_PENDING));
  assign w_empty = (r_count == '0);
  assign w_in    = {bus.i_bofs, bus.i_aofs, bus.i_pc, bus.i_warpid};

  // Gated by reset so no acceptance is signalled while reset is held.
  assign bus.inst_ack = i_rst & bus.inst_rdy & ~w_full;
  assign w_push       = bus.inst_ack;

  assign w_adv = ~(r_vld[LAT-1] & ~bus.wb_ack);
  assign w_pop = w_adv & ~w_empty;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_vld    <= '0;
      r_commit <= 1'b0;
      for (int unsigned i = 0; i < N_PENDING; i++) begin
        r_mem[i] <= '0;
      end
      for (int unsigned i = 0; i < LAT; i++) begin
        r_stg[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_in;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

      if (w_adv) begin
        // Stage 1 loads the FIFO head as it stood before this edge, so an
        // instruction pushed now cannot skip its cycle at the head.
        r_vld[0] <= ~w_empty;
        if (!w_empty) begin
          r_stg[0] <= r_mem[r_rptr];
        end
        for (int unsigned i = 1; i < LAT; i++) begin
          r_vld[i] <= r_vld[i-1];
          r_stg[i] <= r_stg[i-1];
        end
      end

      r_commit <= r_vld[LAT-1] & bus.wb_ack;
    end
  end

  assign bus.wb_rdy           = r_vld[LAT-1];
  assign bus.o_bofs           = r_stg[LAT-1].bofs;
  assign bus.o_aofs           = r_stg[LAT-1].aofs;
  assign bus.o_pc             = r_stg[LAT-1].pc;
  assign bus.o_warpid         = r_stg[LAT-1].warpid;
  assign bus.inst_commit_dval = r_commit;
  assign bus.o_busy           = ~w_empty | (|r_vld);

endmodule

// File: tb/tb_simd_commit_unit.sv
// ---------------------------------------------------------------------------
// tb_simd_commit_unit
//   Bench for simd_commit_unit: fixed per-cycle vector tables, hand-written
//   streaming and reset sequences, then a randomized run against a queue
//   based reference model with an in-order scoreboard.
// ---------------------------------------------------------------------------
module tb_simd_commit_unit;

  localparam int N_PENDING = 4;
  localparam int LAT       = 3;
  localparam int WBW       = 16;
  localparam int VDIM      = 2;
  localparam int INST_BW   = 4;
  localparam int WID_BW    = 2;
  localparam int N_RAND    = 100;

  typedef logic [VDIM-1:0][WBW-1:0] ofs_t;

  typedef struct packed {
    ofs_t                bofs;
    ofs_t                aofs;
    logic [INST_BW-1:0]  pc;
    logic [WID_BW-1:0]   wid;
  } ins_t;

  // One cycle of stimulus with its expected observations.
  typedef struct {
    bit rdy;
    int pc;
    int wid;
    bit wb;
    bit eack;
    bit ewb;
    int epc;
    int ewid;
    bit edval;
    bit ebusy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  vec_t vecs[$];

  simd_commit_unit_if #(
    .WBW(WBW), .VDIM(VDIM), .INST_BW(INST_BW), .WID_BW(WID_BW)
  ) bus ();

  simd_commit_unit #(
    .N_PENDING(N_PENDING), .LAT(LAT), .WBW(WBW), .VDIM(VDIM),
    .INST_BW(INST_BW), .WID_BW(WID_BW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ofs_t mk_ofs(input int pc, input int wid, input int salt);
    logic [31:0] v;
    v = 32'(pc) * 32'h0000_9e37 + 32'(wid) * 32'h0001_3579
      + 32'(salt) * 32'h00a5_5a00 + 32'h0000_1111;
    return v;
  endfunction

  function automatic void add(input bit rdy, input int pc, input int wid, input bit wb,
                              input bit eack, input bit ewb, input int epc, input int ewid,
                              input bit edval, input bit ebusy);
    vec_t v;
    v.rdy = rdy; v.pc = pc; v.wid = wid; v.wb = wb;
    v.eack = eack; v.ewb = ewb; v.epc = epc; v.ewid = ewid;
    v.edval = edval; v.ebusy = ebusy;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rdy, input int pc, input int wid, input bit wb);
    bus.inst_rdy = rdy;
    bus.i_pc     = INST_BW'(pc);
    bus.i_warpid = WID_BW'(wid);
    bus.i_bofs   = mk_ofs(pc, wid, 0);
    bus.i_aofs   = mk_ofs(pc, wid, 1);
    bus.wb_ack   = wb;
  endtask

  // Each cycle task starts 1 time unit after a rising edge and returns at the
  // same point of the following cycle; outputs are sampled 2 units after the edge.
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(vecs[i].rdy, vecs[i].pc, vecs[i].wid, vecs[i].wb);
      #1;
      chk($sformatf("row%0d_ack", i),    64'(bus.inst_ack),         64'(vecs[i].eack));
      chk($sformatf("row%0d_wb_rdy", i), 64'(bus.wb_rdy),           64'(vecs[i].ewb));
      chk($sformatf("row%0d_dval", i),   64'(bus.inst_commit_dval), 64'(vecs[i].edval));
      chk($sformatf("row%0d_busy", i),   64'(bus.o_busy),           64'(vecs[i].ebusy));
      if (vecs[i].ewb) begin
        chk($sformatf("row%0d_pc", i),   64'(bus.o_pc),     64'(vecs[i].epc));
        chk($sformatf("row%0d_wid", i),  64'(bus.o_warpid), 64'(vecs[i].ewid));
        chk($sformatf("row%0d_bofs", i), 64'(bus.o_bofs),
            64'(mk_ofs(vecs[i].epc, vecs[i].ewid, 0)));
        chk($sformatf("row%0d_aofs", i), 64'(bus.o_aofs),
            64'(mk_ofs(vecs[i].epc, vecs[i].ewid, 1)));
      end
      @(posedge clk); #1;
    end
  endtask

  // Reference model state for the randomized phase
  ins_t m_fifo[$];
  ins_t sb[$];
  ins_t m_pd[LAT];
  bit   m_pv[LAT];
  bit   m_dval;
  ins_t pool[N_RAND];

  initial begin
    // ---- vector table -------------------------------------------------
    //   rdy pc wid wb | ack wbrdy epc ewid dval busy
    // Single instruction, pc=5 warp=1, wb_ack tied high (rows 0..6)
    add(1, 5, 1, 1,   1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1,   0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1,   0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1,   0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1,   0, 1, 5, 1, 0, 1);
    add(0, 0, 0, 1,   0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    // Backpressure: 8 offered with wb_ack low, 7 fit; release with FIFO full (rows 7..25)
    add(1, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0,   1, 0, 0, 0, 0, 1);
    add(1, 2, 2, 0,   1, 0, 0, 0, 0, 1);
    add(1, 3, 3, 0,   1, 0, 0, 0, 0, 1);
    add(1, 4, 0, 0,   1, 1, 0, 0, 0, 1);
    add(1, 5, 1, 0,   1, 1, 0, 0, 0, 1);
    add(1, 6, 2, 0,   1, 1, 0, 0, 0, 1);
    add(1, 7, 3, 0,   0, 1, 0, 0, 0, 1);
    add(1, 7, 3, 0,   0, 1, 0, 0, 0, 1);
    add(1, 7, 3, 1,   0, 1, 0, 0, 0, 1);
    add(1, 7, 3, 1,   1, 1, 1, 1, 1, 1);
    add(0, 0, 0, 1,   0, 1, 2, 2, 1, 1);
    add(0, 0, 0, 1,   0, 1, 3, 3, 1, 1);
    add(0, 0, 0, 1,   0, 1, 4, 0, 1, 1);
    add(0, 0, 0, 1,   0, 1, 5, 1, 1, 1);
    add(0, 0, 0, 1,   0, 1, 6, 2, 1, 1);
    add(0, 0, 0, 1,   0, 1, 7, 3, 1, 1);
    add(0, 0, 0, 1,   0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1,   0, 0, 0, 0, 0, 0);

    // ---- reset state ----------------------------------------------------
    rst_n = 1'b0;
    drive(1, 9, 2, 1);
    #2;
    chk("rst_ack",    64'(bus.inst_ack),         64'(0));
    chk("rst_wb_rdy", 64'(bus.wb_rdy),           64'(0));
    chk("rst_busy",   64'(bus.o_busy),           64'(0));
    chk("rst_dval",   64'(bus.inst_commit_dval), 64'(0));
    chk("rst_pc",     64'(bus.o_pc),             64'(0));
    @(posedge clk); @(posedge clk); #1;
    bus.inst_rdy = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    run_rows(0, vecs.size() - 1);

    // ---- back-to-back stream of 8, wb_ack high --------------------------
    for (int c = 0; c < 16; c++) begin
      drive(c < 8, c, c & 3, 1);
      #1;
      if (c < 8) chk("b2b_ack", 64'(bus.inst_ack), 64'(1));
      chk("b2b_dval",   64'(bus.inst_commit_dval), 64'(c >= 5 && c <= 12));
      chk("b2b_wb_rdy", 64'(bus.wb_rdy),           64'(c >= 4 && c <= 11));
      if (c >= 4 && c <= 11) chk("b2b_pc", 64'(bus.o_pc), 64'(c - 4));
      @(posedge clk); #1;
    end

    // ---- reset with 3 instructions in flight ----------------------------
    for (int c = 0; c < 4; c++) begin
      drive(c < 3, 10 + c, 2, 1);
      #1;
      if (c < 3) chk("mid_pre_ack", 64'(bus.inst_ack), 64'(1));
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 1);
    #1;
    chk("mid_pre_wb_rdy", 64'(bus.wb_rdy), 64'(1));
    chk("mid_pre_pc",     64'(bus.o_pc),   64'(10));
    #1;
    rst_n = 1'b0;
    bus.inst_rdy = 1'b1;
    #1;
    chk("mid_rst_wb_rdy", 64'(bus.wb_rdy),           64'(0));
    chk("mid_rst_busy",   64'(bus.o_busy),           64'(0));
    chk("mid_rst_dval",   64'(bus.inst_commit_dval), 64'(0));
    chk("mid_rst_ack",    64'(bus.inst_ack),         64'(0));
    chk("mid_rst_pc",     64'(bus.o_pc),             64'(0));
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #2;
      chk("mid_rst_hold_dval", 64'(bus.inst_commit_dval), 64'(0));
      chk("mid_rst_hold_ack",  64'(bus.inst_ack),         64'(0));
    end
    bus.inst_rdy = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1);
      #1;
      chk("post_rst_dval",   64'(bus.inst_commit_dval), 64'(0));
      chk("post_rst_busy",   64'(bus.o_busy),           64'(0));
      chk("post_rst_wb_rdy", 64'(bus.wb_rdy),           64'(0));
      @(posedge clk); #1;
    end
    run_rows(0, 6);

    // ---- randomized run against the reference model ---------------------
    begin
      int   sent;
      int   dut_commits;
      int   max_out;
      int   cyc;
      bit   rdy, wb, exp_ack, exp_wb, exp_busy, exp_dval, ok, adv;
      ins_t cur, act;

      for (int k = 0; k < N_RAND; k++) begin
        pool[k].bofs = ofs_t'($urandom);
        pool[k].aofs = ofs_t'($urandom);
        pool[k].pc   = INST_BW'($urandom);
        pool[k].wid  = WID_BW'($urandom);
      end
      for (int i = 0; i < LAT; i++) begin
        m_pv[i] = 1'b0;
        m_pd[i] = '0;
      end
      m_dval = 1'b0;
      sent = 0; dut_commits = 0; max_out = 0; cyc = 0;
      cur = '0;

      while (dut_commits < N_RAND && cyc < 5000) begin
        rdy = (sent < N_RAND) && ($urandom_range(0, 9) < 7);
        wb  = 1'($urandom_range(0, 1));
        if (sent < N_RAND) cur = pool[sent];
        bus.inst_rdy = rdy;
        bus.i_bofs   = cur.bofs;
        bus.i_aofs   = cur.aofs;
        bus.i_pc     = cur.pc;
        bus.i_warpid = cur.wid;
        bus.wb_ack   = wb;
        #1;

        exp_ack  = rdy && (m_fifo.size() < N_PENDING);
        exp_wb   = m_pv[LAT-1];
        exp_dval = m_dval;
        exp_busy = (m_fifo.size() != 0);
        for (int i = 0; i < LAT; i++) exp_busy = exp_busy | m_pv[i];
        act = '{bofs: bus.o_bofs, aofs: bus.o_aofs, pc: bus.o_pc, wid: bus.o_warpid};

        ok = (bus.inst_ack === exp_ack) && (bus.wb_rdy === exp_wb) &&
             (bus.inst_commit_dval === exp_dval) && (bus.o_busy === exp_busy) &&
             (!exp_wb || (act === m_pd[LAT-1]));
        n_tests++;
        if (!ok) begin
          n_fail++;
          $display("FAIL rand_c%0d: ack %b/%b wb_rdy %b/%b dval %b/%b busy %b/%b out %h/%h (got/expected)",
                   cyc, bus.inst_ack, exp_ack, bus.wb_rdy, exp_wb, bus.inst_commit_dval, exp_dval,
                   bus.o_busy, exp_busy, act, m_pd[LAT-1]);
        end

        // In-order scoreboard driven by what the DUT actually does
        if (bus.inst_ack === 1'b1) begin
          sb.push_back(cur);
          sent++;
        end
        if (bus.wb_rdy === 1'b1 && wb) begin
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL rand_order_c%0d: retire %h with nothing outstanding", cyc, act);
          end else begin
            if (act !== sb[0]) begin
              n_fail++;
              $display("FAIL rand_order_c%0d: got %h, expected %h", cyc, act, sb[0]);
            end
            void'(sb.pop_front());
          end
        end
        if (bus.inst_commit_dval === 1'b1) dut_commits++;
        if (sb.size() > max_out) max_out = sb.size();

        // Advance the reference model across the coming edge
        adv = !(exp_wb && !wb);
        m_dval = exp_wb && wb;
        if (adv) begin
          for (int i = LAT - 1; i > 0; i--) begin
            m_pv[i] = m_pv[i-1];
            m_pd[i] = m_pd[i-1];
          end
          if (m_fifo.size() != 0) begin
            m_pv[0] = 1'b1;
            m_pd[0] = m_fifo.pop_front();
          end else begin
            m_pv[0] = 1'b0;
          end
        end
        if (exp_ack) m_fifo.push_back(cur);

        @(posedge clk); #1;
        cyc++;
      end

      chk("rand_commit_count",   64'(dut_commits), 64'(N_RAND));
      chk("rand_all_sent",       64'(sent),        64'(N_RAND));
      chk("rand_sb_empty",       64'(sb.size()),   64'(0));
      chk("rand_outstanding_ok", 64'(max_out <= N_PENDING + LAT), 64'(1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
